onehot_grant_scheduler: RTL
===========================

Name: onehot_grant_scheduler

Overview:
- Round-robin scheduler that shares one enabled one-hot decoder output among N requesters.
- Selects a winner index, holds it for a bounded tenure, and presents it in two forms: binary (grant_idx) and decoded one-hot (grant).
- Sits in front of the decoder-style datapath and is the only agent that drives its select and enable.

Parameters:
- IW, 3: index width; requester count N = 2**IW (N is always a power of two).
- MAX_HOLD, 4: maximum consecutive GRANT cycles for one owner; 0 = unlimited tenure.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- enable  input  1  global enable; low forces all grants to zero.
- req  input  N  per-requester request; level-sensitive, bit i = requester i.
- grant  output  N  one-hot grant, registered; all-zero when no owner.
- grant_idx  output  IW  binary index of current owner; holds last value when idle.
- grant_valid  output  1  high exactly when grant is non-zero.
- preempt  output  1  one-cycle pulse when a tenure ends by MAX_HOLD expiry.

Behaviour:
- Reset (rst low at a clk edge):
  - State IDLE; grant=0, grant_idx=0, grant_valid=0, preempt=0.
  - ptr=0, hold_cnt=0.
  - Reset mid-tenure drops grant on the next edge.
- States: IDLE, GRANT, GAP.
- Arbitration function (used in IDLE and GAP):
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ... wrapping modulo N.
  - Evaluated only when enable=1 and req is non-zero.
- IDLE:
  - grant=0.
  - If arbitration yields a winner w: next cycle GRANT, grant_idx=w, grant=onehot(w), hold_cnt=0.
  - Otherwise stay in IDLE.
- GRANT:
  - grant=onehot(grant_idx), grant_valid=1.
  - hold_cnt increments each cycle, saturating.
  - Exit to GAP on any of the following. Priority for preempt reporting: enable=0 first, then req drop, then expiry.
    - enable=0: grant clears on the next edge, preempt=0.
    - req[grant_idx]=0: voluntary release, preempt=0.
    - MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: preempt=1 for the GAP cycle.
  - On every exit, ptr = grant_idx+1 mod N, so it wraps from N-1 to 0.
- GAP:
  - Exactly one dead cycle with grant=0. This is the decoder turnaround; two one-hot grants are never adjacent.
  - Arbitration runs in GAP: if there is a winner, next state is GRANT; otherwise IDLE.
- Latency:
  - From req rising in IDLE to grant: 1 cycle, registered.
  - From release to the next owner's grant: 2 cycles (the GAP cycle, then the new grant).
- Simultaneous events:
  - Release and expiry in the same cycle count as a release (preempt=0).
  - A lone requester that is preempted is re-granted after GAP; fairness is held only by ptr.
- Invariants:
  - grant is zero or exactly one-hot.
  - grant == onehot(grant_idx) whenever grant_valid=1.
  - preempt=1 implies grant_valid=0.
- Width rules:
  - hold_cnt is clog2(MAX_HOLD+1) bits, minimum 1.
  - ptr is IW bits; wrap is natural overflow.

Decomposition:
- Shared package holds:
  - state enum (IDLE/GRANT/GAP).
  - function onehot(idx) returning N bits.
  - function rr_pick(req, ptr) returning {found, idx}.
- One natural sub-module: onehot_idx_decoder.
  - Combinational IW-to-N decoder with enable; all-zero when disabled.
  - Used for the registered grant.

Test Plan:
- Reset: rst=0 for 2 cycles with req=8'hFF → grant=0, grant_idx=0, grant_valid=0, preempt=0. After release, grant=8'h01 one cycle later.
- Rotation: req=8'b1000_0101 held, MAX_HOLD=4 → owner order 0,2,7,0. Each owner gets 4 grant cycles, preempt pulses after each, and there is one zero cycle between owners.
- Voluntary release: owner 2 drops req[2] after 2 cycles while req[5]=1 → one GAP cycle, then grant=8'h20 with preempt=0.
- Wrap: ptr=7, req=8'h81 → owner 7 first, then owner 0 (wrap), never 7 twice in a row.
- Enable low mid-tenure: enable=0 during GRANT → grant=0 next edge and stays zero while enable=0. After enable=1, grant resumes from the ptr-based winner.
- Reset mid-tenure / MAX_HOLD=0: rst=0 during GRANT → all outputs zero next edge. With MAX_HOLD=0 and req[3] held for 100 cycles, grant=8'h08 is continuous and preempt is never asserted.

Source files
------------

// File: rtl/onehot_grant_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_grant_scheduler_pkg
// Description : Shared types and helpers for the one-hot grant scheduler.
//               Holds the scheduler state encoding, a one-hot decode helper
//               and the round-robin pick function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_grant_scheduler_pkg;

  // Helpers work on a fixed maximum width so they can serve any IW below
  // C_MAX_IW. Callers zero-extend their inputs and use the low bits of the
  // results.
  localparam int C_MAX_IW = 6;
  localparam int C_MAX_N  = 1 << C_MAX_IW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                found;
    logic [C_MAX_IW-1:0] idx;
  } pick_t;

  function automatic logic [C_MAX_N-1:0] onehot(input logic [C_MAX_IW-1:0] idx);
    logic [C_MAX_N-1:0] res;
    res      = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

  // First requester found searching ptr, ptr+1, ... modulo (mask+1).
  // The loop runs from the farthest offset down to offset 0 so that the
  // nearest requester is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [C_MAX_N-1:0]  req,
                                    input logic [C_MAX_IW-1:0] ptr,
                                    input logic [C_MAX_IW-1:0] mask);
    pick_t               res;
    logic [C_MAX_IW-1:0] cand;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = C_MAX_N - 1; k >= 0; k--) begin
      cand = (ptr + C_MAX_IW'(k)) & mask;
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_grant_scheduler_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_idx_decoder
// Description : Combinational IW-to-N one-hot decoder with enable. Output is
//               all-zero when disabled.
// Ports       : idx        - binary index in
//               en         - decode enable
//               onehot_out - N-bit one-hot (or zero) out
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_idx_decoder
  import onehot_grant_scheduler_pkg::*;
#(
  parameter int unsigned IW = 3
) (
  input  logic [IW-1:0]       idx,
  input  logic                en,
  output logic [(2**IW)-1:0]  onehot_out
);

  localparam int unsigned N = 1 << IW;

  logic [C_MAX_N-1:0] w_full;
  logic               w_unused_hi;

  assign w_full      = onehot(C_MAX_IW'(idx));
  assign onehot_out  = en ? w_full[N-1:0] : '0;
  // Upper decode bits are never set for a valid IW-bit index.
  assign w_unused_hi = |w_full[C_MAX_N-1:N];

endmodule
`default_nettype wire

// File: rtl/onehot_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : onehot_grant_scheduler
// Description : Round-robin scheduler sharing one enabled one-hot decoder
//               among N = 2**IW requesters. Each owner holds the grant for at
//               most MAX_HOLD cycles (0 = unlimited), and every tenure is
//               followed by one dead GAP cycle for decoder turnaround.
// Ports       : clk         - rising-edge clock
//               rst         - synchronous reset, active-low
//               enable      - global enable, low forces grants to zero
//               req         - per-requester level request
//               grant       - registered one-hot grant
//               grant_idx   - binary owner index, holds when idle
//               grant_valid - high when grant is non-zero
//               preempt     - one-cycle pulse when tenure ends by expiry
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_grant_scheduler
  import onehot_grant_scheduler_pkg::*;
#(
  parameter int unsigned IW       = 3,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [(2**IW)-1:0] req,
  output logic [(2**IW)-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid,
  output logic               preempt
);

  localparam int unsigned N  = 1 << IW;
  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t         r_state;
  state_t         w_next_state;
  logic [IW-1:0]  r_ptr;
  logic [IW-1:0]  w_next_ptr;
  logic [HW-1:0]  r_hold_cnt;
  logic [HW-1:0]  w_next_hold;
  logic [IW-1:0]  w_next_idx;
  logic           w_next_valid;
  logic           w_next_preempt;
  logic [N-1:0]   w_next_grant;

  pick_t          w_pick;
  logic           w_win;
  logic [IW-1:0]  w_win_idx;
  logic           w_drop;
  logic           w_expire;
  logic           w_unused_pick;

  // Arbitration, shared by IDLE and GAP.
  assign w_pick        = rr_pick(C_MAX_N'(req), C_MAX_IW'(r_ptr), C_MAX_IW'(N - 1));
  assign w_win         = enable && (|req) && w_pick.found;
  assign w_win_idx     = w_pick.idx[IW-1:0];
  assign w_unused_pick = |w_pick.idx[C_MAX_IW-1:IW];

  // Tenure-ending conditions while in GRANT. A drop (enable low or owner
  // request gone) outranks expiry for preempt reporting.
  assign w_drop   = !enable || !req[grant_idx];
  assign w_expire = (MAX_HOLD != 0) && (r_hold_cnt == C_HOLD_LAST);

  // State register (also holds all registered outputs).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      grant_idx   <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ptr       <= w_next_ptr;
      r_hold_cnt  <= w_next_hold;
      grant_idx   <= w_next_idx;
      grant       <= w_next_grant;
      grant_valid <= w_next_valid;
      preempt     <= w_next_preempt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_win) w_next_state = ST_GRANT;
      ST_GRANT: if (w_drop || w_expire) w_next_state = ST_GAP;
      ST_GAP:   w_next_state = w_win ? ST_GRANT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: values the output registers take at the next edge.
  always_comb begin
    w_next_idx     = grant_idx;
    w_next_valid   = 1'b0;
    w_next_preempt = 1'b0;
    w_next_ptr     = r_ptr;
    w_next_hold    = r_hold_cnt;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_win) begin
          w_next_idx   = w_win_idx;
          w_next_valid = 1'b1;
          w_next_hold  = '0;
        end
      end
      ST_GRANT: begin
        if (w_drop || w_expire) begin
          w_next_ptr     = grant_idx + 1'b1;
          w_next_preempt = w_expire && !w_drop;
        end else begin
          w_next_valid = 1'b1;
          w_next_hold  = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  onehot_idx_decoder #(
    .IW (IW)
  ) u_dec (
    .idx        (w_next_idx),
    .en         (w_next_valid),
    .onehot_out (w_next_grant)
  );

endmodule
`default_nettype wire
